// File: rtl/sparrow_lsu.sv
// rtl/sparrow_lsu.sv - load/store unit bridging decode control to the data-memory bus
//
// Purpose: aligns store data and byte enables, runs one req/gnt/rvalid bus
// transaction per access, and sign/zero extends load data for writeback.
// The core is stalled while an access is outstanding.
//
// Optional feature macro: SPARROW_LSU_MISALIGN_EXC_EN
//   defined   : misaligned HALF/WORD accesses raise a 1-cycle error/done pulse
//               and never reach the bus.
//   undefined : misaligned offset bits are ignored and the access proceeds.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lsu_req_i           access request, held with all lsu_* inputs until lsu_done_o
//   lsu_wr_en_i         1 = store, 0 = load
//   lsu_size_i          00 byte, 01 half, 11 word (10 treated as word)
//   lsu_zero_extend_i   1 = zero-extend load, 0 = sign-extend
//   lsu_addr_i          byte address
//   lsu_wdata_i         store data
//   lsu_rdata_o         extended load data, nonzero only in the done cycle of a load
//   lsu_stall_o         hold pipeline
//   lsu_done_o          1-cycle completion pulse
//   lsu_err_o           misaligned-access error pulse
//   dmem_*              data-memory bus (req/gnt handshake, rvalid response)

module sparrow_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_req_i,
    input  logic            lsu_wr_en_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_zero_extend_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_stall_o,
    output logic            lsu_done_o,
    output logic            lsu_err_o,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
`ifdef SPARROW_LSU_MISALIGN_EXC_EN
        , S_ERR = 2'b11
`endif
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic [XLEN-1:2]   r_addr;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_zext;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_wdata;

    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_lane;
    logic [XLEN-1:0]   w_ext;
    logic              w_err;

    // Effective lane offset: half accesses only honour addr[1], words always
    // use lane 0, so misaligned low bits are dropped here when not trapped.
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                w_off   = lsu_addr_i[1:0];
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                w_off   = {lsu_addr_i[1], 1'b0};
                w_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                w_wdata = {2{lsu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef SPARROW_LSU_MISALIGN_EXC_EN
    logic w_misaligned;
    // size[1] covers both WORD and the illegal encoding handled as WORD
    assign w_misaligned = ((lsu_size_i == 2'b01) && lsu_addr_i[0]) ||
                          (lsu_size_i[1] && (lsu_addr_i[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_zext  <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && lsu_req_i) begin
                r_addr  <= lsu_addr_i[XLEN-1:2];
                r_off   <= w_off;
                r_size  <= lsu_size_i;
                r_we    <= lsu_wr_en_i;
                r_zext  <= lsu_zero_extend_i;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        dmem_req_o = 1'b0;
        lsu_done_o = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) begin
`ifdef SPARROW_LSU_MISALIGN_EXC_EN
                    w_next = w_misaligned ? S_ERR : S_REQ;
`else
                    w_next = S_REQ;
`endif
                end
            end
            S_REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    lsu_done_o = 1'b1;
                    w_next     = S_IDLE;
                end
            end
`ifdef SPARROW_LSU_MISALIGN_EXC_EN
            S_ERR: begin
                lsu_done_o = 1'b1;
                w_err      = 1'b1;
                w_next     = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign w_lane = dmem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_ext = {{(XLEN-8){~r_zext & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_ext = {{(XLEN-16){~r_zext & w_lane[15]}}, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    // Only a completing load returns data; stores and errors report zero.
    assign lsu_rdata_o  = ((r_state == S_WAIT) && dmem_rvalid_i && !r_we) ? w_ext : '0;
    assign lsu_stall_o  = lsu_req_i & ~lsu_done_o;
    assign lsu_err_o    = w_err;
    assign dmem_addr_o  = {r_addr, 2'b00};
    assign dmem_we_o    = r_we;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

endmodule

// File: tb/tb_sparrow_lsu.sv
// tb/tb_sparrow_lsu.sv - directed self-checking bench for sparrow_lsu

module tb_sparrow_lsu;

    logic        clk;
    logic        rst_n;
    logic        lsu_req_i;
    logic        lsu_wr_en_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_zero_extend_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic        lsu_err_o;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int checks;
    int failures;

    // Values observed by run_access
    logic        o_done;
    int          o_lat;
    int          o_req_cycles;
    logic        o_stable;
    logic        o_stall_ok;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic        o_we;
    logic [31:0] o_wdata;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_err_seen;

    sparrow_lsu #(.XLEN(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_req_i         (lsu_req_i),
        .lsu_wr_en_i       (lsu_wr_en_i),
        .lsu_size_i        (lsu_size_i),
        .lsu_zero_extend_i (lsu_zero_extend_i),
        .lsu_addr_i        (lsu_addr_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_done_o        (lsu_done_o),
        .lsu_err_o         (lsu_err_o),
        .dmem_req_o        (dmem_req_o),
        .dmem_gnt_i        (dmem_gnt_i),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_be_o         (dmem_be_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_rvalid_i     (dmem_rvalid_i),
        .dmem_rdata_i      (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one access and act as the memory: grant after gnt_delay
    // requesting cycles, answer with rd one cycle after the grant.
    // Cycle 1 is the cycle in which lsu_req_i is first presented.
    task automatic run_access(input logic we, input logic [1:0] size, input logic zext,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int gnt_delay);
        logic waiting;
        @(posedge clk); #1;
        lsu_req_i = 1'b1; lsu_wr_en_i = we; lsu_size_i = size;
        lsu_zero_extend_i = zext; lsu_addr_i = addr; lsu_wdata_i = wd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        o_done = 1'b0; o_lat = 0; o_req_cycles = 0; o_stable = 1'b1; o_stall_ok = 1'b1;
        o_rdata = 32'h0; o_err = 1'b0; o_err_seen = 1'b0; waiting = 1'b0;
        o_addr = 32'h0; o_be = 4'h0; o_we = 1'b0; o_wdata = 32'h0;
        for (int c = 1; c <= 30 && !o_done; c++) begin
            @(negedge clk);
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (waiting) begin
                dmem_rvalid_i = 1'b1; dmem_rdata_i = rd;
            end
            if (dmem_req_o) begin
                if (o_req_cycles == 0) begin
                    o_addr = dmem_addr_o; o_be = dmem_be_o; o_we = dmem_we_o; o_wdata = dmem_wdata_o;
                end else if (o_addr !== dmem_addr_o || o_be !== dmem_be_o || o_wdata !== dmem_wdata_o) begin
                    o_stable = 1'b0;
                end
                o_req_cycles++;
                if (o_req_cycles > gnt_delay) begin
                    dmem_gnt_i = 1'b1; waiting = 1'b1;
                end
            end
            #1;
            if (lsu_err_o) o_err_seen = 1'b1;
            if (lsu_done_o) begin
                o_done = 1'b1; o_lat = c; o_rdata = lsu_rdata_o; o_err = lsu_err_o;
            end else if (!lsu_stall_o) begin
                o_stall_ok = 1'b0;
            end
        end
        @(posedge clk); #1;
        lsu_req_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lsu_req_i = 1'b0; lsu_wr_en_i = 1'b0; lsu_size_i = 2'b00;
        lsu_zero_extend_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dmem_req_o, lsu_done_o, lsu_err_o, lsu_stall_o, dmem_we_o} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {dmem_req_o, lsu_done_o, lsu_err_o, lsu_stall_o, dmem_we_o});
        end
        checks++;
        if ({dmem_addr_o, dmem_wdata_o, dmem_be_o, lsu_rdata_o} !== 100'h0) begin
            failures++; $display("FAIL reset_data addr=%h wdata=%h be=%b rdata=%h exp=0", dmem_addr_o, dmem_wdata_o, dmem_be_o, lsu_rdata_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_access(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++;
        if (o_lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", o_lat); end
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
            failures++; $display("FAIL lw_bus addr=%h be=%b we=%b exp=00000100 1111 0", o_addr, o_be, o_we);
        end
        checks++;
        if (o_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", o_rdata); end
        checks++;
        if (o_stall_ok !== 1'b1) begin failures++; $display("FAIL lw_stall got=%b exp=1", o_stall_ok); end
        @(negedge clk);
        checks++;
        if (lsu_stall_o !== 1'b0 || lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0 || dmem_req_o !== 1'b0) begin
            failures++; $display("FAIL lw_after stall=%b done=%b rdata=%h req=%b exp=0", lsu_stall_o, lsu_done_o, lsu_rdata_o, dmem_req_o);
        end
    endtask

    task automatic test_loads_ext();
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
        checks++;
        if (o_rdata !== 32'hFFFF_FF80 || o_be !== 4'b1000) begin
            failures++; $display("FAIL lb_sext got=%h be=%b exp=ffffff80 1000", o_rdata, o_be);
        end
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
        checks++;
        if (o_rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", o_rdata); end
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7F00, 0);
        checks++;
        if (o_rdata !== 32'hFFFF_8001 || o_be !== 4'b1100) begin
            failures++; $display("FAIL lh_sext got=%h be=%b exp=ffff8001 1100", o_rdata, o_be);
        end
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_7F00, 0);
        checks++;
        if (o_rdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_zext got=%h exp=00008001", o_rdata); end
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0);
        checks++;
        if (o_rdata !== 32'h0000_007F) begin failures++; $display("FAIL lb_pos got=%h exp=0000007f", o_rdata); end
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h8765_4321, 0);
        checks++;
        if (o_rdata !== 32'h8765_4321 || o_be !== 4'b1111 || o_addr !== 32'h104) begin
            failures++; $display("FAIL size10_word got=%h be=%b addr=%h exp=87654321 1111 00000104", o_rdata, o_be, o_addr);
        end
    endtask

    task automatic test_store();
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
        checks++;
        if (o_wdata !== 32'hABCD_ABCD || o_be !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h200) begin
            failures++; $display("FAIL sh_bus wdata=%h be=%b we=%b addr=%h exp=abcdabcd 1100 1 00000200", o_wdata, o_be, o_we, o_addr);
        end
        checks++;
        if (o_lat !== 3 || o_rdata !== 32'h0) begin
            failures++; $display("FAIL sh_done lat=%0d rdata=%h exp=3 00000000", o_lat, o_rdata);
        end
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'hCAFE_0077, 32'h0, 0);
        checks++;
        if (o_wdata !== 32'h7777_7777 || o_be !== 4'b0010 || o_we !== 1'b1) begin
            failures++; $display("FAIL sb_bus wdata=%h be=%b we=%b exp=77777777 0010 1", o_wdata, o_be, o_we);
        end
        run_access(1'b1, 2'b11, 1'b0, 32'h0000_0400, 32'h0BAD_F00D, 32'h0, 0);
        checks++;
        if (o_wdata !== 32'h0BAD_F00D || o_be !== 4'b1111) begin
            failures++; $display("FAIL sw_bus wdata=%h be=%b exp=0badf00d 1111", o_wdata, o_be);
        end
    endtask

    task automatic test_gnt_delay();
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0502, 32'h0000_00A5, 32'h0, 4);
        checks++;
        if (o_req_cycles !== 5 || o_stable !== 1'b1) begin
            failures++; $display("FAIL gnt_delay_stable req_cycles=%0d stable=%b exp=5 1", o_req_cycles, o_stable);
        end
        checks++;
        if (o_lat !== 7 || o_stall_ok !== 1'b1) begin
            failures++; $display("FAIL gnt_delay_done lat=%0d stall_ok=%b exp=7 1", o_lat, o_stall_ok);
        end
        checks++;
        if (o_wdata !== 32'hA5A5_A5A5 || o_be !== 4'b0100) begin
            failures++; $display("FAIL gnt_delay_bus wdata=%h be=%b exp=a5a5a5a5 0100", o_wdata, o_be);
        end
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        lsu_req_i = 1'b1; lsu_wr_en_i = 1'b0; lsu_size_i = 2'b11;
        lsu_zero_extend_i = 1'b0; lsu_addr_i = 32'h0000_0100;
        @(negedge clk);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || lsu_done_o !== 1'b0 || lsu_stall_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid req=%b done=%b stall=%b exp=0 0 1", dmem_req_o, lsu_done_o, lsu_stall_o);
        end
        lsu_req_i = 1'b0;
        #1;
        checks++;
        if (lsu_stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", lsu_stall_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0 || dmem_req_o !== 1'b0) begin
            failures++; $display("FAIL late_rvalid done=%b rdata=%h req=%b exp=0", lsu_done_o, lsu_rdata_o, dmem_req_o);
        end
        dmem_rvalid_i = 1'b0;
        run_access(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 0);
        checks++;
        if (o_lat !== 3 || o_rdata !== 32'h5555_AAAA) begin
            failures++; $display("FAIL post_rst_lw lat=%0d rdata=%h exp=3 5555aaaa", o_lat, o_rdata);
        end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 2'b11, 1'b0, 32'h0000_0102, 32'h0, 32'h1357_9BDF, 0);
`ifdef SPARROW_LSU_MISALIGN_EXC_EN
        checks++;
        if (o_done !== 1'b1 || o_err !== 1'b1 || o_lat !== 2 || o_rdata !== 32'h0) begin
            failures++; $display("FAIL misalign_err done=%b err=%b lat=%0d rdata=%h exp=1 1 2 0", o_done, o_err, o_lat, o_rdata);
        end
        checks++;
        if (o_req_cycles !== 0) begin failures++; $display("FAIL misalign_noreq got=%0d exp=0", o_req_cycles); end
`else
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_lat !== 3 || o_rdata !== 32'h1357_9BDF) begin
            failures++; $display("FAIL misalign_pass addr=%h be=%b lat=%0d rdata=%h exp=00000100 1111 3 13579bdf", o_addr, o_be, o_lat, o_rdata);
        end
        checks++;
        if (o_err_seen !== 1'b0) begin failures++; $display("FAIL misalign_noerr got=%b exp=0", o_err_seen); end
`endif
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 32'hF00F_0000, 0);
`ifdef SPARROW_LSU_MISALIGN_EXC_EN
        checks++;
        if (o_err !== 1'b1 || o_req_cycles !== 0) begin
            failures++; $display("FAIL misalign_half err=%b req_cycles=%0d exp=1 0", o_err, o_req_cycles);
        end
`else
        checks++;
        if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_F00F || o_err_seen !== 1'b0) begin
            failures++; $display("FAIL misalign_half be=%b rdata=%h err=%b exp=1100 fffff00f 0", o_be, o_rdata, o_err_seen);
        end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lw();
        test_loads_ext();
        test_store();
        test_gnt_delay();
        test_reset_mid_op();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
